// File: rtl/mestre_end_i2c.sv
// I2C master address transmitter: START, 7-bit address + R/W, ACK sample, STOP.
// SCL is derived from clk by a quarter-period counter; all bus outputs are registered.
module mestre_end_i2c #(
   parameter int unsigned DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [6:0] endereco,
   input  logic       leitura,
   input  logic       sda_in,
   output logic       scl,
   output logic       sda_out,
   output logic       sda_oe,
   output logic       ocupado,
   output logic       concluido,
   output logic       ack_ok
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned QTR_W = 2;
   localparam int unsigned BIT_W = 3;
   localparam int unsigned SR_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [QTR_W-1:0]   qtr_q, qtr_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [SR_W-1:0]    sreg_q, sreg_d;
   logic               ocupado_q, ocupado_d;
   logic               concluido_q, concluido_d;
   logic               ack_ok_q, ack_ok_d;
   logic               scl_q, scl_d;
   logic               sda_q, sda_d;
   logic               oe_q, oe_d;
   logic               qtr_end;
   logic               timed;

   assign qtr_end = (cnt_q == CNT_W'(DIV - 1));
   assign timed   = (state_q == ST_START) || (state_q == ST_BIT) ||
                    (state_q == ST_ACK)   || (state_q == ST_STOP);

   // State, counters and registered outputs; reset leaves the bus idle immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         qtr_q       <= '0;
         bit_q       <= '0;
         sreg_q      <= '0;
         ocupado_q   <= 1'b0;
         concluido_q <= 1'b0;
         ack_ok_q    <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         oe_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         qtr_q       <= qtr_d;
         bit_q       <= bit_d;
         sreg_q      <= sreg_d;
         ocupado_q   <= ocupado_d;
         concluido_q <= concluido_d;
         ack_ok_q    <= ack_ok_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         oe_q        <= oe_d;
      end
   end

   // Next-state: quarter timing, phase sequencing, shift register and status flags.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      qtr_d       = qtr_q;
      bit_d       = bit_q;
      sreg_d      = sreg_q;
      ocupado_d   = ocupado_q;
      concluido_d = 1'b0;
      ack_ok_d    = ack_ok_q;

      if (timed) begin
         cnt_d = qtr_end ? '0 : cnt_q + CNT_W'(1);
         if (qtr_end) begin
            qtr_d = qtr_q + QTR_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (iniciar) begin
               state_d   = ST_START;
               cnt_d     = '0;
               qtr_d     = '0;
               bit_d     = '0;
               sreg_d    = {endereco, leitura};
               ocupado_d = 1'b1;
               ack_ok_d  = 1'b0;
            end
         end
         ST_START: begin
            if (qtr_end && (qtr_q == QTR_W'(1))) begin
               state_d = ST_BIT;
               qtr_d   = '0;
            end
         end
         ST_BIT: begin
            if (qtr_end && (qtr_q == QTR_W'(3))) begin
               sreg_d = {sreg_q[SR_W-2:0], 1'b0};
               if (bit_q == BIT_W'(7)) begin
                  state_d = ST_ACK;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         ST_ACK: begin
            // Sample the slave response in the middle of the SCL-high half.
            if (qtr_end && (qtr_q == QTR_W'(2))) begin
               ack_ok_d = ~sda_in;
            end
            if (qtr_end && (qtr_q == QTR_W'(3))) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (qtr_end && (qtr_q == QTR_W'(3))) begin
               state_d     = ST_DONE;
               ocupado_d   = 1'b0;
               concluido_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus levels decoded from the upcoming state/quarter so they register alongside it.
   always_comb begin
      scl_d = 1'b1;
      sda_d = 1'b1;
      oe_d  = 1'b1;
      case (state_d)
         ST_START: begin
            sda_d = 1'b0;
         end
         ST_BIT: begin
            scl_d = qtr_d[1];
            sda_d = sreg_d[SR_W-1];
         end
         ST_ACK: begin
            scl_d = qtr_d[1];
            oe_d  = 1'b0;
         end
         ST_STOP: begin
            scl_d = qtr_d[1];
            sda_d = (qtr_d == QTR_W'(3));
         end
         default: begin
            scl_d = 1'b1;
            sda_d = 1'b1;
            oe_d  = 1'b1;
         end
      endcase
   end

   assign scl       = scl_q;
   assign sda_out   = sda_q;
   assign sda_oe    = oe_q;
   assign ocupado   = ocupado_q;
   assign concluido = concluido_q;
   assign ack_ok    = ack_ok_q;

endmodule

// File: tb/tb_mestre_end_i2c.sv
// Bench for mestre_end_i2c: two instances (DIV=4, DIV=2) checked cycle by cycle against
// a waveform built from the quarter-level bus protocol.
module tb_mestre_end_i2c;

   localparam int unsigned DIV_A = 4;
   localparam int unsigned DIV_B = 2;

   logic       clk;
   logic       reset;
   logic [1:0] iniciar_v;
   logic [1:0] leitura_v;
   logic [1:0] sda_in_v;
   logic [6:0] endereco_v [2];
   logic [1:0] scl_v;
   logic [1:0] sda_out_v;
   logic [1:0] sda_oe_v;
   logic [1:0] ocupado_v;
   logic [1:0] concluido_v;
   logic [1:0] ack_ok_v;

   int n_checks;
   int n_fail;

   mestre_end_i2c #(.DIV(DIV_A)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .iniciar   (iniciar_v[0]),
      .endereco  (endereco_v[0]),
      .leitura   (leitura_v[0]),
      .sda_in    (sda_in_v[0]),
      .scl       (scl_v[0]),
      .sda_out   (sda_out_v[0]),
      .sda_oe    (sda_oe_v[0]),
      .ocupado   (ocupado_v[0]),
      .concluido (concluido_v[0]),
      .ack_ok    (ack_ok_v[0])
   );

   mestre_end_i2c #(.DIV(DIV_B)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .iniciar   (iniciar_v[1]),
      .endereco  (endereco_v[1]),
      .leitura   (leitura_v[1]),
      .sda_in    (sda_in_v[1]),
      .scl       (scl_v[1]),
      .sda_out   (sda_out_v[1]),
      .sda_oe    (sda_oe_v[1]),
      .ocupado   (ocupado_v[1]),
      .concluido (concluido_v[1]),
      .ack_ok    (ack_ok_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // {ocupado, concluido, scl, sda (1 when released), oe, ack_ok}
   function automatic logic [7:0] obs(input int d);
      logic sda_eff;
      sda_eff = sda_oe_v[d] ? sda_out_v[d] : 1'b1;
      return {2'b00, ocupado_v[d], concluido_v[d], scl_v[d], sda_eff, sda_oe_v[d], ack_ok_v[d]};
   endfunction

   // One full transfer on instance d; entered and left at a falling clk edge.
   task automatic run_xfer(input int d, input logic [6:0] addr, input logic rw,
                           input logic ack_lvl, input logic hold, input int glitch_at);
      int           div;
      logic [7:0]   byte_out;
      logic [2:0]   qs [$];
      logic [2:0]   wav [$];
      logic [7:0]   got;
      logic         prev_ack;
      div      = (d == 0) ? int'(DIV_A) : int'(DIV_B);
      byte_out = {addr, rw};
      prev_ack = ~ack_lvl;
      // quarter table, each entry {scl, sda, oe}
      qs.push_back(3'b101);
      qs.push_back(3'b101);
      for (int b = 7; b >= 0; b--) begin
         qs.push_back({1'b0, byte_out[b], 1'b1});
         qs.push_back({1'b0, byte_out[b], 1'b1});
         qs.push_back({1'b1, byte_out[b], 1'b1});
         qs.push_back({1'b1, byte_out[b], 1'b1});
      end
      qs.push_back(3'b010);
      qs.push_back(3'b010);
      qs.push_back(3'b110);
      qs.push_back(3'b110);
      qs.push_back(3'b001);
      qs.push_back(3'b001);
      qs.push_back(3'b101);
      qs.push_back(3'b111);
      foreach (qs[k]) begin
         for (int r = 0; r < div; r++) wav.push_back(qs[k]);
      end

      endereco_v[d] = addr;
      leitura_v[d]  = rw;
      sda_in_v[d]   = ack_lvl;
      iniciar_v[d]  = 1'b1;
      @(posedge clk);
      for (int i = 0; i < wav.size(); i++) begin
         @(negedge clk);
         got = obs(d);
         chk($sformatf("wave d%0d c%0d", d, i), {3'b000, got[5:1]},
             {3'b000, 2'b10, wav[i]});
         if (i == 0) iniciar_v[d] = hold;
         if (i == glitch_at) begin
            iniciar_v[d]  = 1'b1;
            endereco_v[d] = 7'h7F;
            leitura_v[d]  = ~rw;
         end else if (i == glitch_at + 1) begin
            iniciar_v[d] = hold;
         end
      end
      @(negedge clk);
      chk($sformatf("done d%0d", d), obs(d), {2'b00, 2'b01, 3'b111, prev_ack});
      @(negedge clk);
      chk($sformatf("idle d%0d", d), obs(d), {2'b00, 2'b00, 3'b111, prev_ack});
   endtask

   initial begin
      logic [7:0] idle_exp;
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b0;
      iniciar_v     = 2'b00;
      leitura_v     = 2'b00;
      sda_in_v      = 2'b11;
      endereco_v[0] = 7'h00;
      endereco_v[1] = 7'h00;
      idle_exp      = 8'b0000_1110;

      #12;
      chk("reset a", obs(0), idle_exp);
      chk("reset b", obs(1), idle_exp);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // ACKed write to 0x55, then NACKed read from 0x3A
      run_xfer(0, 7'h55, 1'b0, 1'b0, 1'b0, -1);
      run_xfer(0, 7'h3A, 1'b1, 1'b1, 1'b0, -1);
      // restart request and address change during the transfer are ignored
      run_xfer(0, 7'h2C, 1'b0, 1'b0, 1'b0, 50);

      // async reset in the middle of bit 3
      endereco_v[0] = 7'h6B;
      leitura_v[0]  = 1'b0;
      sda_in_v[0]   = 1'b0;
      iniciar_v[0]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iniciar_v[0] = 1'b0;
      repeat (61) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midreset a", obs(0), idle_exp);
      @(negedge clk);
      reset = 1'b1;
      run_xfer(0, 7'h01, 1'b0, 1'b0, 1'b0, -1);

      // faster divider
      run_xfer(1, 7'h00, 1'b0, 1'b0, 1'b0, -1);

      // iniciar held high: back-to-back transfers
      run_xfer(0, 7'($urandom), 1'($urandom), 1'($urandom), 1'b1, -1);
      run_xfer(0, 7'($urandom), 1'($urandom), 1'($urandom), 1'b1, -1);
      run_xfer(0, 7'($urandom), 1'($urandom), 1'($urandom), 1'b0, -1);

      // randomized transfers on both instances
      for (int n = 0; n < 8; n++) begin
         int d;
         int g;
         d = int'($urandom_range(0, 1));
         g = ($urandom_range(0, 1) == 0) ? -1
             : int'($urandom_range(0, 42 * ((d == 0) ? DIV_A : DIV_B) - 2));
         run_xfer(d, 7'($urandom), 1'($urandom), 1'($urandom), 1'b0, g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
